timer_cmp_core: RTL and testbench
=================================

Name: timer_cmp_core

Overview:
- Next-generation free-running timer core with a programmable prescaler, a parametrised counter width and N_CH independent compare channels.
- Each channel raises a sticky interrupt, in either one-shot or periodic mode.
- A software sample strobe captures the counter into a stable readout register.
- Sits behind the TIMER software-register bank; the CPU reads TIMER_VALUE split into DATA_W-wide low/high words.

Parameters:
- DATA_W, 32, CPU data word width; CNT_W must be a multiple of DATA_W.
- CNT_W, 64, counter and compare width.
- N_CH, 4, number of compare channels (1..8).
- PRESC_W, 16, prescaler reload width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- TIMER_ENABLE  in  1  count enable (level).
- TIMER_CLEAR  in  1  synchronous soft clear of counter and prescaler (pulse).
- TIMER_SAMPLE  in  1  capture counter into TIMER_VALUE (pulse).
- PRESCALE  in  PRESC_W  tick every PRESCALE+1 enabled cycles.
- CMP_VALUE  in  N_CH*CNT_W  per-channel interval; channel i occupies bits [i*CNT_W +: CNT_W].
- CMP_MODE  in  N_CH  per channel: 0 = one-shot, 1 = periodic.
- CMP_LOAD  in  N_CH  arm channel i (pulse).
- CMP_STOP  in  N_CH  disarm channel i (pulse).
- IRQ_CLR  in  N_CH  clear sticky IRQ i (pulse).
- TIMER_VALUE  out  CNT_W  last sampled counter value.
- OVF  out  1  sticky counter-wrap flag; cleared by TIMER_CLEAR.
- IRQ  out  N_CH  sticky per-channel interrupt flags.
- IRQ_ANY  out  1  OR-reduction of IRQ, registered.

Behaviour:
- Reset (rst high, asynchronous): counter=0, prescaler=0, TIMER_VALUE=0, OVF=0, IRQ=0, IRQ_ANY=0, every channel IDLE, target=0.
- Prescaler:
  - When TIMER_ENABLE=1, presc_cnt increments each cycle.
  - When presc_cnt==PRESCALE: tick=1 and presc_cnt returns to 0.
  - PRESCALE=0 gives a tick on every enabled cycle.
  - With TIMER_ENABLE=0, presc_cnt holds and tick=0.
  - A PRESCALE change takes effect from the next compare; if presc_cnt>PRESCALE, it wraps to 0 next cycle with no tick.
- Counter:
  - On tick, counter <= counter+1, modulo 2^CNT_W.
  - The increment from all-ones to 0 sets OVF.
- TIMER_CLEAR has priority over tick: counter=0, presc_cnt=0, OVF=0. Channels and IRQ are unaffected.
- Sample:
  - TIMER_SAMPLE=1 loads TIMER_VALUE with the pre-edge counter value, visible the next cycle.
  - Sample coinciding with a tick returns the un-incremented value.
  - TIMER_VALUE holds between samples.
- Channel FSM, per channel:
  - IDLE -> ARMED on CMP_LOAD with CMP_VALUE!=0; target <= counter_next + CMP_VALUE (modulo 2^CNT_W). counter_next is the value the counter takes at this same edge.
  - CMP_LOAD with CMP_VALUE==0 leaves or forces the channel IDLE.
  - ARMED: on a tick where counter+1 == target, IRQ[i] is set at that same edge. Then:
    - periodic: target <= target + CMP_VALUE, stay ARMED (drift-free);
    - one-shot: go to DONE.
  - DONE -> ARMED on CMP_LOAD; DONE -> IDLE on CMP_STOP.
  - ARMED -> IDLE on CMP_STOP.
  - CMP_LOAD in ARMED re-arms relative to the current counter.
  - CMP_LOAD and CMP_STOP in the same cycle: STOP wins.
- Match while TIMER_CLEAR is active: no match, since the counter is forced to 0. Targets are not adjusted; software re-loads.
- Counter wrap: compare is pure equality, so targets across a wrap fire correctly.
- IRQ[i]: set by a match, cleared by IRQ_CLR[i]; set wins when both occur in the same cycle. IRQ_ANY lags IRQ by one cycle.
- CMP_VALUE and CMP_MODE are sampled at load and at each periodic reload only.

Decomposition:
- Shared header timer_cmp.vh holds:
  - channel state encodings: IDLE=2'd0, ARMED=2'd1, DONE=2'd2;
  - mode encodings: ONESHOT=1'b0, PERIODIC=1'b1;
  - CSR width macros for the added registers.
- Sub-module timer_cmp_ch, one per channel via generate, contains FSM, target register and IRQ flag. Inputs: counter, counter_next, tick, clear.
- The top keeps prescaler, counter, OVF and sample register.

Test Plan:
1. Reset mid-count: ENABLE=1, PRESCALE=0, assert rst after 10 cycles -> all outputs 0 asynchronously; SAMPLE after release returns counts from 0.
2. Prescaler: PRESCALE=3, ENABLE for 40 cycles, SAMPLE -> TIMER_VALUE=10. ENABLE=0 for 20 cycles, SAMPLE -> still 10.
3. Periodic channel: PRESCALE=0, counter=0, CMP_LOAD[0] with CMP_VALUE=5, mode periodic -> IRQ[0] set when counter reaches 5. After IRQ_CLR, set again at 10, then 15. IRQ_CLR and match in the same cycle -> IRQ stays 1.
4. One-shot plus stop: ch1 one-shot, CMP_VALUE=3 -> IRQ[1] once at +3, then no further set. Load ch2, CMP_STOP before match -> IRQ[2] never sets.
5. Wrap: CNT_W=8 build, counter at 250, CMP_LOAD value 10 -> match at counter 4; OVF=1 after 255->0; TIMER_CLEAR -> OVF=0, counter=0.
6. Sample/tick collision: SAMPLE on a tick edge while counter=7 -> TIMER_VALUE=7. CMP_LOAD with CMP_VALUE=0 -> channel IDLE, no IRQ.

Source files
------------

// File: rtl/timer_cmp_core_pkg.sv
// Shared definitions for the timer compare core.
// - ch_state_e : per-channel compare FSM state encoding
// - Mode*      : CMP_MODE bit encodings
package timer_cmp_core_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StDone  = 2'd2
    } ch_state_e;

    localparam logic ModeOneShot  = 1'b0;
    localparam logic ModePeriodic = 1'b1;

endpackage

// File: rtl/timer_cmp_core_if.sv
// Register-bank side bundle of the timer compare core.
// master : software register bank (drives controls, reads status)
// slave  : timer_cmp_core
interface timer_cmp_core_if #(
    parameter int unsigned CNT_W   = 64,
    parameter int unsigned N_CH    = 4,
    parameter int unsigned PRESC_W = 16
) ();

    logic                   TIMER_ENABLE;
    logic                   TIMER_CLEAR;
    logic                   TIMER_SAMPLE;
    logic [PRESC_W-1:0]     PRESCALE;
    logic [N_CH*CNT_W-1:0]  CMP_VALUE;
    logic [N_CH-1:0]        CMP_MODE;
    logic [N_CH-1:0]        CMP_LOAD;
    logic [N_CH-1:0]        CMP_STOP;
    logic [N_CH-1:0]        IRQ_CLR;
    logic [CNT_W-1:0]       TIMER_VALUE;
    logic                   OVF;
    logic [N_CH-1:0]        IRQ;
    logic                   IRQ_ANY;

    modport master (
        output TIMER_ENABLE, TIMER_CLEAR, TIMER_SAMPLE, PRESCALE,
        output CMP_VALUE, CMP_MODE, CMP_LOAD, CMP_STOP, IRQ_CLR,
        input  TIMER_VALUE, OVF, IRQ, IRQ_ANY
    );

    modport slave (
        input  TIMER_ENABLE, TIMER_CLEAR, TIMER_SAMPLE, PRESCALE,
        input  CMP_VALUE, CMP_MODE, CMP_LOAD, CMP_STOP, IRQ_CLR,
        output TIMER_VALUE, OVF, IRQ, IRQ_ANY
    );

endinterface

// File: rtl/timer_cmp_core_ch.sv
// One compare channel: IDLE/ARMED/DONE FSM, absolute target and sticky IRQ.
// Ports:
//   clk, rst          clock, async active-high reset
//   counter_i         current counter value
//   counter_next_i    value the counter takes at this edge
//   tick_i, clear_i   prescaler tick and soft clear
//   cmp_value_i       interval, cmp_mode_i one-shot/periodic
//   load_i, stop_i    arm / disarm pulses (stop wins)
//   irq_clr_i         clear sticky IRQ (a simultaneous match wins)
//   irq_o             sticky interrupt flag
module timer_cmp_core_ch
    import timer_cmp_core_pkg::*;
#(
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] counter_i,
    input  logic [CNT_W-1:0] counter_next_i,
    input  logic             tick_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] cmp_value_i,
    input  logic             cmp_mode_i,
    input  logic             load_i,
    input  logic             stop_i,
    input  logic             irq_clr_i,
    output logic             irq_o
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic             mode_q, mode_d;
    logic             irq_q, irq_d;
    logic             match;

    always_comb begin
        // Pure equality on the incremented count, so targets beyond a wrap still hit.
        match    = (state_q == StArmed) && tick_i && !clear_i &&
                   ((counter_i + CNT_W'(1)) == target_q);
        state_d  = state_q;
        target_d = target_q;
        mode_d   = mode_q;

        if (stop_i) begin
            state_d = StIdle;
        end else if (load_i) begin
            if (cmp_value_i != '0) begin
                state_d  = StArmed;
                target_d = counter_next_i + cmp_value_i;
                mode_d   = cmp_mode_i;
            end else begin
                state_d = StIdle;
            end
        end else if (match) begin
            case (mode_q)
                ModePeriodic: begin
                    // Advance from the old target, not the counter, to stay drift-free.
                    target_d = target_q + cmp_value_i;
                    mode_d   = cmp_mode_i;
                end
                ModeOneShot: state_d = StDone;
                default:     state_d = StDone;
            endcase
        end

        irq_d = match | (irq_q & ~irq_clr_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            target_q <= '0;
            mode_q   <= ModeOneShot;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            mode_q   <= mode_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_o = irq_q;

endmodule

// File: rtl/timer_cmp_core.sv
// Free-running prescaled timer with N_CH compare channels and a sample register.
// Ports:
//   clk, rst  clock, async active-high reset
//   bus       timer_cmp_core_if.slave: controls in, TIMER_VALUE/OVF/IRQ/IRQ_ANY out
// The sample register is held as DATA_W-wide words for the low/high CPU reads.
module timer_cmp_core
    import timer_cmp_core_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CNT_W   = 64,
    parameter int unsigned N_CH    = 4,
    parameter int unsigned PRESC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    timer_cmp_core_if.slave  bus
);

    localparam int unsigned NumWords = CNT_W / DATA_W;

    logic [PRESC_W-1:0]              presc_cnt_q, presc_cnt_d;
    logic [CNT_W-1:0]                counter_q, counter_d;
    logic                            ovf_q, ovf_d;
    logic [NumWords-1:0][DATA_W-1:0] sample_q, sample_d;
    logic                            irq_any_q, irq_any_d;
    logic                            tick;
    logic [N_CH-1:0]                 irq;

    always_comb begin
        tick        = 1'b0;
        presc_cnt_d = presc_cnt_q;
        if (bus.TIMER_CLEAR) begin
            presc_cnt_d = '0;
        end else if (bus.TIMER_ENABLE) begin
            if (presc_cnt_q == bus.PRESCALE) begin
                tick        = 1'b1;
                presc_cnt_d = '0;
            end else if (presc_cnt_q > bus.PRESCALE) begin
                // PRESCALE was lowered below the running count: restart, no tick.
                presc_cnt_d = '0;
            end else begin
                presc_cnt_d = presc_cnt_q + PRESC_W'(1);
            end
        end

        counter_d = counter_q;
        ovf_d     = ovf_q;
        if (bus.TIMER_CLEAR) begin
            counter_d = '0;
            ovf_d     = 1'b0;
        end else if (tick) begin
            counter_d = counter_q + CNT_W'(1);
            if (&counter_q) begin
                ovf_d = 1'b1;
            end
        end

        sample_d = sample_q;
        if (bus.TIMER_SAMPLE) begin
            sample_d = counter_q;
        end

        irq_any_d = |irq;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_cnt_q <= '0;
            counter_q   <= '0;
            ovf_q       <= 1'b0;
            sample_q    <= '0;
            irq_any_q   <= 1'b0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
            counter_q   <= counter_d;
            ovf_q       <= ovf_d;
            sample_q    <= sample_d;
            irq_any_q   <= irq_any_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        timer_cmp_core_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk            (clk),
            .rst            (rst),
            .counter_i      (counter_q),
            .counter_next_i (counter_d),
            .tick_i         (tick),
            .clear_i        (bus.TIMER_CLEAR),
            .cmp_value_i    (bus.CMP_VALUE[i*CNT_W +: CNT_W]),
            .cmp_mode_i     (bus.CMP_MODE[i]),
            .load_i         (bus.CMP_LOAD[i]),
            .stop_i         (bus.CMP_STOP[i]),
            .irq_clr_i      (bus.IRQ_CLR[i]),
            .irq_o          (irq[i])
        );
    end

    assign bus.TIMER_VALUE = sample_q;
    assign bus.OVF         = ovf_q;
    assign bus.IRQ         = irq;
    assign bus.IRQ_ANY     = irq_any_q;

endmodule

// File: tb/tb_timer_cmp_core.sv
// Bench for timer_cmp_core (8-bit counter build so wraps are reachable).
// Driver sets inputs on the falling edge and pushes the reference model's
// post-edge outputs into a queue; the monitor pops and compares after each
// rising edge.
module tb_timer_cmp_core;

    localparam int unsigned DW  = 8;
    localparam int unsigned CW  = 8;
    localparam int unsigned NC  = 4;
    localparam int unsigned PW  = 4;
    localparam int          Mod = 1 << CW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    timer_cmp_core_if #(.CNT_W(CW), .N_CH(NC), .PRESC_W(PW)) bus ();

    timer_cmp_core #(
        .DATA_W  (DW),
        .CNT_W   (CW),
        .N_CH    (NC),
        .PRESC_W (PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    logic [13:0] expq[$];

    // Reference model state
    int m_c, m_p, m_tv, m_ovf, m_any;
    int m_tgt[NC];
    bit m_arm[NC], m_per[NC], m_irq[NC];

    task automatic model_reset();
        m_c = 0; m_p = 0; m_tv = 0; m_ovf = 0; m_any = 0;
        for (int ch = 0; ch < NC; ch++) begin
            m_tgt[ch] = 0; m_arm[ch] = 0; m_per[ch] = 0; m_irq[ch] = 0;
        end
    endtask

    function automatic logic [13:0] model_out();
        logic [3:0] iv;
        for (int ch = 0; ch < NC; ch++) iv[ch] = m_irq[ch];
        return {m_tv[7:0], m_ovf[0], iv, m_any[0]};
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        bit tick, hit, any;
        int cn, v;
        if (rst) begin
            model_reset();
        end else begin
            tick = !bus.TIMER_CLEAR && bus.TIMER_ENABLE && (m_p == int'(bus.PRESCALE));
            cn   = bus.TIMER_CLEAR ? 0 : (tick ? (m_c + 1) % Mod : m_c);
            any  = 0;
            for (int ch = 0; ch < NC; ch++) any |= m_irq[ch];
            for (int ch = 0; ch < NC; ch++) begin
                v   = int'(bus.CMP_VALUE[ch*CW +: CW]);
                hit = m_arm[ch] && tick && (((m_c + 1) % Mod) == m_tgt[ch]);
                if (hit) m_irq[ch] = 1;
                else if (bus.IRQ_CLR[ch]) m_irq[ch] = 0;
                if (bus.CMP_STOP[ch]) begin
                    m_arm[ch] = 0;
                end else if (bus.CMP_LOAD[ch]) begin
                    if (v != 0) begin
                        m_arm[ch] = 1;
                        m_tgt[ch] = (cn + v) % Mod;
                        m_per[ch] = bus.CMP_MODE[ch];
                    end else begin
                        m_arm[ch] = 0;
                    end
                end else if (hit) begin
                    if (m_per[ch]) begin
                        m_tgt[ch] = (m_tgt[ch] + v) % Mod;
                        m_per[ch] = bus.CMP_MODE[ch];
                    end else begin
                        m_arm[ch] = 0;
                    end
                end
            end
            if (bus.TIMER_SAMPLE) m_tv = m_c;
            if (bus.TIMER_CLEAR) m_ovf = 0;
            else if (tick && m_c == Mod - 1) m_ovf = 1;
            if (bus.TIMER_CLEAR) m_p = 0;
            else if (bus.TIMER_ENABLE) m_p = (m_p >= int'(bus.PRESCALE)) ? 0 : m_p + 1;
            m_c   = cn;
            m_any = any;
        end
        expq.push_back(model_out());
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
    endtask

    task automatic pulses_off();
        bus.TIMER_CLEAR  = 1'b0;
        bus.TIMER_SAMPLE = 1'b0;
        bus.CMP_LOAD     = '0;
        bus.CMP_STOP     = '0;
        bus.IRQ_CLR      = '0;
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic set_ch(input int ch, input int val, input bit mode);
        bus.CMP_VALUE[ch*CW +: CW] = CW'(val);
        bus.CMP_MODE[ch]           = mode;
    endtask

    // Monitor / scoreboard
    initial begin
        logic [13:0] exp_v, got_v;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                exp_v = expq.pop_front();
                got_v = {bus.TIMER_VALUE, bus.OVF, bus.IRQ, bus.IRQ_ANY};
                compared++;
                if (got_v !== exp_v) begin
                    mismatched++;
                    $display("FAIL outputs @%0t: got tv=%0d ovf=%b irq=%b any=%b, expected tv=%0d ovf=%b irq=%b any=%b",
                             $time, got_v[13:6], got_v[5], got_v[4:1], got_v[0],
                             exp_v[13:6], exp_v[5], exp_v[4:1], exp_v[0]);
                end
            end
        end
    end

    // Driver
    initial begin
        rst = 1'b1;
        bus.TIMER_ENABLE = 1'b0;
        bus.PRESCALE     = '0;
        bus.CMP_VALUE    = '0;
        bus.CMP_MODE     = '0;
        pulses_off();
        model_reset();
        step();
        step();
        rst = 1'b0;

        // Reset mid-count
        bus.TIMER_ENABLE = 1'b1;
        repeat (10) step();
        bus.TIMER_SAMPLE = 1'b1;
        step();
        pulses_off();
        step();
        rst = 1'b1;
        #1;
        check_val("async_reset_outputs",
                  int'({bus.TIMER_VALUE, bus.OVF, bus.IRQ, bus.IRQ_ANY}), 0);
        step();
        step();
        rst = 1'b0;
        repeat (3) step();
        bus.TIMER_SAMPLE = 1'b1;
        step();
        pulses_off();

        // Prescaler: PRESCALE=3, 40 enabled cycles -> 10 ticks
        bus.TIMER_ENABLE = 1'b0;
        bus.TIMER_CLEAR  = 1'b1;
        step();
        pulses_off();
        bus.PRESCALE     = PW'(3);
        bus.TIMER_ENABLE = 1'b1;
        repeat (40) step();
        bus.TIMER_ENABLE = 1'b0;
        bus.TIMER_SAMPLE = 1'b1;
        step();
        pulses_off();
        check_val("presc_sample", int'(bus.TIMER_VALUE), 10);
        repeat (20) step();
        bus.TIMER_SAMPLE = 1'b1;
        step();
        pulses_off();
        check_val("presc_hold", int'(bus.TIMER_VALUE), 10);

        // Periodic ch0 interval 5, armed at the clearing edge
        bus.PRESCALE     = '0;
        bus.TIMER_ENABLE = 1'b1;
        bus.TIMER_CLEAR  = 1'b1;
        set_ch(0, 5, 1'b1);
        bus.CMP_LOAD[0]  = 1'b1;
        step();
        pulses_off();
        for (int k = 0; k < 17; k++) begin
            bus.IRQ_CLR[0]   = (k == 6 || k == 9);   // k==9 collides with the match at 10
            bus.TIMER_SAMPLE = 1'b1;
            step();
            pulses_off();
        end

        // One-shot ch1 (3) and ch2 stopped before its match
        set_ch(1, 3, 1'b0);
        set_ch(2, 8, 1'b0);
        bus.CMP_LOAD[1] = 1'b1;
        bus.CMP_LOAD[2] = 1'b1;
        step();
        pulses_off();
        step();
        bus.CMP_STOP[2] = 1'b1;
        step();
        pulses_off();
        repeat (20) step();

        // Wrap: load ch3 near the top of the range
        bus.CMP_STOP    = 4'b0001;
        bus.TIMER_CLEAR = 1'b1;
        step();
        pulses_off();
        repeat (249) step();
        set_ch(3, 10, 1'b0);
        bus.CMP_LOAD[3]  = 1'b1;
        bus.TIMER_SAMPLE = 1'b1;
        step();
        pulses_off();
        for (int k = 0; k < 20; k++) begin
            bus.TIMER_SAMPLE = 1'b1;
            step();
        end
        pulses_off();
        bus.TIMER_CLEAR = 1'b1;
        step();
        pulses_off();
        bus.TIMER_SAMPLE = 1'b1;
        step();
        pulses_off();

        // Sample/tick collision at counter 7, zero-interval load
        bus.IRQ_CLR     = '1;
        bus.TIMER_CLEAR = 1'b1;
        step();
        pulses_off();
        repeat (7) step();
        bus.TIMER_SAMPLE = 1'b1;
        set_ch(0, 0, 1'b1);
        bus.CMP_LOAD[0]  = 1'b1;
        step();
        pulses_off();
        check_val("sample_tick_collision", int'(bus.TIMER_VALUE), 7);
        repeat (20) step();

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            bus.TIMER_ENABLE = ($urandom_range(0, 9) != 0);
            bus.TIMER_CLEAR  = ($urandom_range(0, 499) == 0);
            bus.TIMER_SAMPLE = $urandom_range(0, 1);
            if ($urandom_range(0, 99) == 0) bus.PRESCALE = PW'($urandom_range(0, 3));
            for (int ch = 0; ch < NC; ch++) begin
                bus.CMP_LOAD[ch] = ($urandom_range(0, 39) == 0);
                bus.CMP_STOP[ch] = ($urandom_range(0, 79) == 0);
                bus.IRQ_CLR[ch]  = ($urandom_range(0, 7) == 0);
                if (bus.CMP_LOAD[ch])
                    set_ch(ch, ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12),
                           1'($urandom_range(0, 1)));
            end
            step();
        end
        pulses_off();
        @(negedge clk);
        @(negedge clk);
        check_val("scoreboard_drained", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
